arbitro_rr_param: RTL and testbench

ARBITRO_RR_PARAM -- requirements
Module: arbitro_rr_param

---
 rtl/arbitro_rr_param.sv | 214 +++++++++++++++++++++
 tb/tb_arbitro_rr_param.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_rr_param.sv
// Input-queued crossbar arbiter: per-port VC selection (strict or round-robin),
// per-output round-robin port arbitration, one-cycle registered output stage.

module arbitro_rr_param_port #(
    parameter int NUM_VC = 2,
    parameter int DATA_W = 5,
    parameter int DEST_W = 1,
    parameter int VC_W   = 1
) (
    input  logic                     arb_mode,
    input  logic [NUM_VC-1:0]        elig,
    input  logic [NUM_VC-1:0]        oor,
    input  logic [NUM_VC*DATA_W-1:0] data,
    input  logic [VC_W-1:0]          vc_ptr,
    output logic                     cand_vld,
    output logic [VC_W-1:0]          cand_vc,
    output logic                     cand_oor,
    output logic [DATA_W-1:0]        cand_data,
    output logic [DEST_W-1:0]        cand_dest
);

    // Descending scan: the last hit (smallest offset) wins.
    always_comb begin
        cand_vld = 1'b0;
        cand_vc  = '0;
        for (int k = NUM_VC - 1; k >= 0; k--) begin
            if (arb_mode) begin
                if (elig[(int'(vc_ptr) + k) % NUM_VC]) begin
                    cand_vld = 1'b1;
                    cand_vc  = VC_W'((int'(vc_ptr) + k) % NUM_VC);
                end
            end else if (elig[k]) begin
                cand_vld = 1'b1;
                cand_vc  = VC_W'(k);
            end
        end
    end

    always_comb begin
        cand_data = data[int'(cand_vc) * DATA_W +: DATA_W];
        cand_dest = cand_data[DATA_W-1 -: DEST_W];
        cand_oor  = cand_vld & oor[cand_vc];
    end

endmodule

module arbitro_rr_param #(
    parameter int NUM_PORTS = 2,
    parameter int NUM_VC    = 2,
    parameter int DATA_W    = 5
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              arb_mode,
    input  logic [NUM_PORTS*NUM_VC*DATA_W-1:0] vc_data,
    input  logic [NUM_PORTS*NUM_VC-1:0]       vc_empty,
    output logic [NUM_PORTS*NUM_VC-1:0]       vc_pop,
    input  logic [NUM_PORTS-1:0]              out_full,
    output logic [NUM_PORTS-1:0]              push_out,
    output logic [NUM_PORTS*DATA_W-1:0]       data_out,
    output logic                              err_dest
);

    localparam int DEST_W    = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
    localparam int PORT_W    = DEST_W;
    localparam int VC_W      = (NUM_VC > 2) ? $clog2(NUM_VC) : 1;
    localparam int NQ        = NUM_PORTS * NUM_VC;
    localparam int DEST_SPAN = 1 << DEST_W;

    logic [DEST_SPAN-1:0]                  full_ext;
    logic [NQ-1:0]                         q_elig;
    logic [NQ-1:0]                         q_oor;

    logic [NUM_PORTS-1:0]                  cand_vld;
    logic [NUM_PORTS-1:0]                  cand_oor;
    logic [NUM_PORTS-1:0][VC_W-1:0]        cand_vc;
    logic [NUM_PORTS-1:0][DATA_W-1:0]      cand_data;
    logic [NUM_PORTS-1:0][DEST_W-1:0]      cand_dest;

    logic [NUM_PORTS-1:0][NUM_PORTS-1:0]   gnt;
    logic [NUM_PORTS-1:0][PORT_W-1:0]      win_port;
    logic [NUM_PORTS-1:0]                  any_gnt;
    logic [NUM_PORTS-1:0]                  port_pop;

    logic [NUM_PORTS-1:0][PORT_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NUM_PORTS-1:0][VC_W-1:0]        vc_ptr_q, vc_ptr_d;
    logic [NUM_PORTS-1:0]                  push_q, push_d;
    logic [NUM_PORTS-1:0][DATA_W-1:0]      data_q, data_d;
    logic                                  err_q, err_d;

    // Unused destination codes read as "not full" so out-of-range words stay eligible.
    for (genvar i = 0; i < DEST_SPAN; i++) begin : g_full
        if (i < NUM_PORTS) begin : g_real
            assign full_ext[i] = out_full[i];
        end else begin : g_pad
            assign full_ext[i] = 1'b0;
        end
    end

    for (genvar q = 0; q < NQ; q++) begin : g_q
        logic [DEST_W-1:0] q_dest;
        assign q_dest = vc_data[q*DATA_W + DATA_W-1 -: DEST_W];
        if (DEST_SPAN > NUM_PORTS) begin : g_chk
            assign q_oor[q] = (q_dest > DEST_W'(NUM_PORTS - 1));
        end else begin : g_nochk
            assign q_oor[q] = 1'b0;
        end
        assign q_elig[q] = !vc_empty[q] && (q_oor[q] || !full_ext[q_dest]);
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        arbitro_rr_param_port #(
            .NUM_VC (NUM_VC),
            .DATA_W (DATA_W),
            .DEST_W (DEST_W),
            .VC_W   (VC_W)
        ) u_port (
            .arb_mode  (arb_mode),
            .elig      (q_elig[p*NUM_VC +: NUM_VC]),
            .oor       (q_oor[p*NUM_VC +: NUM_VC]),
            .data      (vc_data[p*NUM_VC*DATA_W +: NUM_VC*DATA_W]),
            .vc_ptr    (vc_ptr_q[p]),
            .cand_vld  (cand_vld[p]),
            .cand_vc   (cand_vc[p]),
            .cand_oor  (cand_oor[p]),
            .cand_data (cand_data[p]),
            .cand_dest (cand_dest[p])
        );
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        logic [NUM_PORTS-1:0] req, gnt_row;
        logic [VC_W-1:0]      min_vc;
        logic [PORT_W-1:0]    win;

        always_comb begin
            req    = '0;
            min_vc = VC_W'(NUM_VC - 1);
            for (int p = 0; p < NUM_PORTS; p++)
                req[p] = cand_vld[p] && !cand_oor[p] && (cand_dest[p] == DEST_W'(o));
            for (int p = 0; p < NUM_PORTS; p++)
                if (req[p] && (cand_vc[p] < min_vc)) min_vc = cand_vc[p];
            // Strict mode: only the highest class present at this output competes.
            if (!arb_mode)
                for (int p = 0; p < NUM_PORTS; p++)
                    if (cand_vc[p] != min_vc) req[p] = 1'b0;
            gnt_row = '0;
            win     = '0;
            for (int k = NUM_PORTS - 1; k >= 0; k--) begin
                if (req[(int'(rr_ptr_q[o]) + k) % NUM_PORTS]) begin
                    gnt_row = '0;
                    gnt_row[(int'(rr_ptr_q[o]) + k) % NUM_PORTS] = 1'b1;
                    win = PORT_W'((int'(rr_ptr_q[o]) + k) % NUM_PORTS);
                end
            end
        end

        assign gnt[o]      = gnt_row;
        assign win_port[o] = win;
        assign any_gnt[o]  = |gnt_row;
    end

    always_comb begin
        port_pop = cand_vld & cand_oor;
        for (int o = 0; o < NUM_PORTS; o++)
            for (int p = 0; p < NUM_PORTS; p++)
                if (gnt[o][p]) port_pop[p] = 1'b1;
    end

    always_comb begin
        vc_pop = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            for (int v = 0; v < NUM_VC; v++)
                vc_pop[p*NUM_VC + v] = !reset && port_pop[p] && (cand_vc[p] == VC_W'(v));
    end

    always_comb begin
        push_d   = any_gnt;
        data_d   = data_q;
        rr_ptr_d = rr_ptr_q;
        vc_ptr_d = vc_ptr_q;
        err_d    = |(cand_vld & cand_oor);
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (any_gnt[o]) begin
                data_d[o]   = cand_data[win_port[o]];
                rr_ptr_d[o] = PORT_W'((int'(win_port[o]) + 1) % NUM_PORTS);
            end
        end
        for (int p = 0; p < NUM_PORTS; p++)
            if (arb_mode && port_pop[p])
                vc_ptr_d[p] = VC_W'((int'(cand_vc[p]) + 1) % NUM_VC);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            push_q   <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            rr_ptr_q <= '0;
            vc_ptr_q <= '0;
        end else begin
            push_q   <= push_d;
            data_q   <= data_d;
            err_q    <= err_d;
            rr_ptr_q <= rr_ptr_d;
            vc_ptr_q <= vc_ptr_d;
        end
    end

    assign push_out = push_q;
    assign data_out = data_q;
    assign err_dest = err_q;

endmodule

// File: tb/tb_arbitro_rr_param.sv
// Directed bench: expected output pushes go to a scoreboard drained by a monitor;
// pops, error pulses and reset behaviour are checked inline.

module tb_arbitro_rr_param;

    localparam int NP = 2, NV = 2, DW = 5, NQ = 4;
    localparam int NP3 = 3, NQ3 = 6;

    logic              clk = 1'b0;
    logic              reset;

    logic              arb_mode;
    logic [NQ*DW-1:0]  vc_data;
    logic [NQ-1:0]     vc_empty, vc_pop;
    logic [NP-1:0]     out_full, push_out;
    logic [NP*DW-1:0]  data_out;
    logic              err_dest;

    logic              arb_mode3;
    logic [NQ3*DW-1:0] vc_data3;
    logic [NQ3-1:0]    vc_empty3, vc_pop3;
    logic [NP3-1:0]    out_full3, push_out3;
    logic [NP3*DW-1:0] data_out3;
    logic              err_dest3;

    arbitro_rr_param dut (
        .clk(clk), .reset(reset), .arb_mode(arb_mode), .vc_data(vc_data),
        .vc_empty(vc_empty), .vc_pop(vc_pop), .out_full(out_full),
        .push_out(push_out), .data_out(data_out), .err_dest(err_dest)
    );

    arbitro_rr_param #(.NUM_PORTS(NP3), .NUM_VC(NV), .DATA_W(DW)) dut3 (
        .clk(clk), .reset(reset), .arb_mode(arb_mode3), .vc_data(vc_data3),
        .vc_empty(vc_empty3), .vc_pop(vc_pop3), .out_full(out_full3),
        .push_out(push_out3), .data_out(data_out3), .err_dest(err_dest3)
    );

    always #5 clk = ~clk;

    typedef struct { int o; logic [DW-1:0] d; } exp_t;
    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_push(input int o, input logic [DW-1:0] d);
        sb.push_back('{o, d});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One arbitration cycle on the 2-port instance: drive, then check the pop vector.
    task automatic cyc(input string name, input logic m, input logic [NQ*DW-1:0] d,
                       input logic [NQ-1:0] e, input logic [NP-1:0] f, input logic [NQ-1:0] exp_pop);
        tick();
        arb_mode = m; vc_data = d; vc_empty = e; out_full = f;
        #1;
        chk(name, 32'(vc_pop), 32'(exp_pop));
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                for (int o = 0; o < NP; o++) begin
                    if (push_out[o]) begin
                        n_tests++;
                        if (sb.size() == 0) begin
                            n_fail++;
                            $display("FAIL sb_unexpected: out %0d data %b, expected no push", o, data_out[o*DW +: DW]);
                        end else begin
                            e = sb.pop_front();
                            if (e.o != o || e.d !== data_out[o*DW +: DW]) begin
                                n_fail++;
                                $display("FAIL sb_push: got out %0d data %b, expected out %0d data %b",
                                         o, data_out[o*DW +: DW], e.o, e.d);
                            end
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        arb_mode = 1'b0; vc_empty = '0; out_full = '0;
        vc_data = {4{5'b00011}};
        arb_mode3 = 1'b0; vc_empty3 = '0; out_full3 = '0;
        vc_data3 = {6{5'b00011}};
        fork monitor(); join_none

        // Reset with every queue non-empty
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_pop", 32'(vc_pop), 32'd0);
            chk("rst_push", 32'(push_out), 32'd0);
            chk("rst_data", 32'(data_out), 32'd0);
            chk("rst_pop3", 32'(vc_pop3), 32'd0);
        end
        tick();
        vc_empty = '1; vc_empty3 = '1;
        reset = 1'b0;

        // Single word port0 VC0 -> output 1
        cyc("single_pop", 1'b0, {15'd0, 5'b10010}, 4'b1110, 2'b00, 4'b0001);
        expect_push(1, 5'b10010);
        cyc("single_idle", 1'b0, '0, 4'b1111, 2'b00, 4'b0000);
        chk("single_push", 32'(push_out), 32'b10);

        // Both ports VC0 to output 0, strict mode: alternate starting at port0
        for (int i = 0; i < 4; i++) begin
            cyc("alt_pop", 1'b0, {5'b00000, 5'b00001, 5'b00000, 5'b00011}, 4'b1010, 2'b00,
                (i % 2 == 0) ? 4'b0001 : 4'b0100);
            expect_push(0, (i % 2 == 0) ? 5'b00011 : 5'b00001);
        end

        // Port0 VC1 vs port1 VC0 to output 0: strict -> port1 always
        for (int i = 0; i < 3; i++) begin
            cyc("strict_pop", 1'b0, {5'b00000, 5'b00110, 5'b00101, 5'b00000}, 4'b1001, 2'b00, 4'b0100);
            expect_push(0, 5'b00110);
        end
        // Round-robin mode -> ports alternate
        for (int i = 0; i < 4; i++) begin
            cyc("rr_pop", 1'b1, {5'b00000, 5'b00110, 5'b00101, 5'b00000}, 4'b1001, 2'b00,
                (i % 2 == 0) ? 4'b0010 : 4'b0100);
            expect_push(0, (i % 2 == 0) ? 5'b00101 : 5'b00110);
        end

        // Output 1 full: VC0 blocked, VC1 proceeds; then VC0 once space frees
        cyc("hol_vc1", 1'b0, {5'b00000, 5'b00000, 5'b01000, 5'b10111}, 4'b1100, 2'b10, 4'b0010);
        expect_push(0, 5'b01000);
        cyc("hol_vc0", 1'b0, {5'b00000, 5'b00000, 5'b00000, 5'b10111}, 4'b1110, 2'b00, 4'b0001);
        expect_push(1, 5'b10111);
        cyc("idle_pop", 1'b0, '0, 4'b1111, 2'b00, 4'b0000);
        tick();
        chk("idle_push", 32'(push_out), 32'd0);
        chk("idle_hold", 32'(data_out), 32'({5'b10111, 5'b01000}));

        // 3-port instance: out-of-range destination 3 is discarded
        vc_data3 = {25'd0, 5'b11001}; vc_empty3 = 6'b111110;
        #1;
        chk("oor_pop3", 32'(vc_pop3), 32'b000001);
        tick();
        vc_empty3 = '1;
        #1;
        chk("oor_err3", 32'(err_dest3), 32'd1);
        chk("oor_push3", 32'(push_out3), 32'd0);
        chk("oor_pop3_idle", 32'(vc_pop3), 32'd0);
        tick();
        chk("oor_err3_clear", 32'(err_dest3), 32'd0);

        // Grant to output 2, then reset while the push is visible
        vc_data3 = {25'd0, 5'b10100}; vc_empty3 = 6'b111110;
        #1;
        chk("xfer_pop3", 32'(vc_pop3), 32'b000001);
        tick();
        vc_empty3 = '1;
        #1;
        chk("xfer_push3", 32'(push_out3), 32'b100);
        chk("xfer_data3", 32'(data_out3[2*DW +: DW]), 32'(5'b10100));
        vc_empty3 = 6'b111110;
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_push3", 32'(push_out3), 32'd0);
        chk("midrst_data3", 32'(data_out3), 32'd0);
        chk("midrst_pop3", 32'(vc_pop3), 32'd0);
        tick();
        vc_empty3 = '1;
        reset = 1'b0;

        // Ports 0 and 2 contend for output 2: pointer is back at 0, so port0 wins
        tick();
        vc_data3 = {5'd0, 5'b10010, 15'd0, 5'b10001}; vc_empty3 = 6'b101110;
        #1;
        chk("post_rst_pop3", 32'(vc_pop3), 32'b000001);
        tick();
        vc_empty3 = '1;
        #1;
        chk("post_rst_push3", 32'(push_out3), 32'b100);
        chk("post_rst_data3", 32'(data_out3[2*DW +: DW]), 32'(5'b10001));

        repeat (3) tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
